onehot_index_decoder: RTL and testbench
=======================================

// Module: onehot_index_decoder
// PURPOSE
//  Inverse of the 8->3 priority encoder. Takes a stream of binary indices and
//  emits the matching one-hot vector, which drives per-lane enables and grants.
//  Both sides use a valid/ready handshake. The output is registered, and a
//  2-entry skid buffer gives full throughput.
// PARAMETERS
//  IDX_W   3          width of the input index
//  OUT_W   8          width of the one-hot output; must be <= 2**IDX_W
//  CNT_W   8          width of the saturating out-of-range counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        in_idx is valid
//  in_ready    out  1        decoder can accept a beat
//  in_idx      in   IDX_W    binary index to decode
//  out_valid   out  1        out_onehot is valid
//  out_ready   in   1        downstream accepts the beat
//  out_onehot  out  OUT_W    one-hot vector; bit in_idx is set
//  out_err     out  1        the beat's index was >= OUT_W
//  err_cnt     out  CNT_W    saturating count of out-of-range beats
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream) clears:
//    out_valid=0, out_onehot=0, out_err=0, err_cnt=0, skid empty, in_ready=0.
//    in_ready rises on the first clk edge after rst_n goes high.
//  - Handshakes:
//    - Input accept = in_valid & in_ready.
//    - Output transfer = out_valid & out_ready.
//    - in_valid must not depend on in_ready. out_valid never drops until the
//      beat transfers.
//  - Latency: 1 cycle from input accept to out_valid, with an empty skid.
//  - Decode: out_onehot = 1 << in_idx when in_idx < OUT_W.
//    - Otherwise out_onehot = 0 and out_err = 1.
//    - out_err is per-beat. It travels with its beat.
//  - Skid states:
//    - EMPTY: output reg free or draining.
//    - ONE: output reg valid.
//    - FULL: output reg valid and skid reg valid.
//    - in_ready = (state != FULL). It is registered, with no comb path from
//      out_ready.
//  - Transitions:
//    - EMPTY -> ONE on accept.
//    - ONE -> ONE on accept with transfer.
//    - ONE -> FULL on accept without transfer.
//    - ONE -> EMPTY on transfer without accept.
//    - FULL -> ONE on transfer. The skid entry moves to the output reg.
//  - Beat order is always preserved.
//  - Simultaneous accept + transfer in ONE: the new beat loads the output reg
//    in the same edge.
//  - err_cnt increments on input accept of an out-of-range index. It holds at
//    2**CNT_W-1.
//  - With OUT_W == 2**IDX_W, out_err is constant 0 and err_cnt stays 0.
//  - Reset mid-operation drops all in-flight beats. No partial beat is ever
//    presented.
// CONFIGURATION
//  ONEHOT_DEC_THERMO_EN
//  - Defined: adds output port out_thermo [OUT_W].
//    - Bits [in_idx:0] are set, for example idx 3 -> 8'b0000_1111.
//    - The port is registered and skidded with the beat, and resets to 0.
//    - It is all-zero on out-of-range beats.
//  - Undefined: the port and its registers are absent. All other behaviour is
//    identical.
// TESTING
//  1. Reset, then accept idx=5 with out_ready=1 -> next cycle out_valid=1,
//     out_onehot=8'b0010_0000, out_err=0.
//  2. Stream idx 0..7 back-to-back, out_ready=1 -> 8 beats on consecutive
//     cycles, onehot 0x01..0x80, in_ready stays 1.
//  3. out_ready=0, send idx 2,4,6 -> in_ready=0 after the 2nd accept.
//     Release out_ready -> 0x04, 0x10, then 0x40 accepted and emitted, in order.
//  4. OUT_W=6, send idx 7 -> out_onehot=0, out_err=1, err_cnt=1.
//     Send 300 out-of-range beats -> err_cnt=255.
//  5. Assert rst_n low while FULL -> all outputs 0 immediately.
//     After release, in_ready=1 in 1 cycle and no stale beat appears.
//  6. With ONEHOT_DEC_THERMO_EN, send idx 3 -> out_thermo=8'b0000_1111.
//     Send idx 0 -> 8'b0000_0001.

Source files
------------

// File: rtl/onehot_index_decoder.sv
// onehot_index_decoder: binary index -> one-hot vector with valid/ready on both sides.
// The output register is backed by one skid entry, so the input can be accepted every
// cycle while in_ready stays registered (no combinational path from out_ready).
// Optional feature macro: ONEHOT_DEC_THERMO_EN adds a thermometer-coded output
// (out_thermo) that travels with each beat.
module onehot_index_decoder #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
`ifdef ONEHOT_DEC_THERMO_EN
    ,
    output logic [OUT_W-1:0] out_thermo
`endif
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_t;

    // Payload carried per beat: {thermo (optional), err, onehot}.
`ifdef ONEHOT_DEC_THERMO_EN
    localparam int unsigned PAY_W = 2 * OUT_W + 1;
`else
    localparam int unsigned PAY_W = OUT_W + 1;
`endif

    localparam logic [IDX_W:0] LP_OUT_W = (IDX_W + 1)'(OUT_W);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [PAY_W-1:0]   r_out_pay;
    logic [PAY_W-1:0]   r_skid_pay;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_accept;
    logic               w_xfer;
    logic               w_in_range;
    logic [OUT_W-1:0]   w_onehot;
`ifdef ONEHOT_DEC_THERMO_EN
    logic [OUT_W-1:0]   w_thermo;
`endif
    logic [PAY_W-1:0]   w_pay;

    assign w_accept   = in_valid & r_in_ready;
    assign w_xfer     = r_out_valid & out_ready;
    assign w_in_range = ({1'b0, in_idx} < LP_OUT_W);

    // Decode the incoming index into the beat payload; out-of-range yields zeros plus err.
    always_comb begin
        w_onehot = '0;
`ifdef ONEHOT_DEC_THERMO_EN
        w_thermo = '0;
`endif
        for (int i = 0; i < OUT_W; i++) begin
            w_onehot[i] = w_in_range && (in_idx == IDX_W'(i));
`ifdef ONEHOT_DEC_THERMO_EN
            w_thermo[i] = w_in_range && ((IDX_W + 1)'(i) <= {1'b0, in_idx});
`endif
        end
`ifdef ONEHOT_DEC_THERMO_EN
        w_pay = {w_thermo, ~w_in_range, w_onehot};
`else
        w_pay = {~w_in_range, w_onehot};
`endif
    end

    // Skid FSM: output register plus one skid entry, in_ready registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StEmpty;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pay   <= '0;
            r_skid_pay  <= '0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    // Also the first edge after reset, which is what raises in_ready.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_out_pay   <= w_pay;
                        r_out_valid <= 1'b1;
                        r_state     <= StOne;
                    end
                end
                StOne: begin
                    if (w_accept && w_xfer) begin
                        r_out_pay <= w_pay;
                    end else if (w_accept) begin
                        r_skid_pay <= w_pay;
                        r_in_ready <= 1'b0;
                        r_state    <= StFull;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StEmpty;
                    end
                end
                StFull: begin
                    if (w_xfer) begin
                        r_out_pay  <= r_skid_pay;
                        r_in_ready <= 1'b1;
                        r_state    <= StOne;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= StEmpty;
                end
            endcase
        end
    end

    // Saturating count of accepted out-of-range indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_onehot = r_out_pay[OUT_W-1:0];
    assign out_err    = r_out_pay[OUT_W];
    assign err_cnt    = r_err_cnt;
`ifdef ONEHOT_DEC_THERMO_EN
    assign out_thermo = r_out_pay[2*OUT_W:OUT_W+1];
`endif

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Bench for onehot_index_decoder: a default 8-lane instance and a 6-lane instance
// (for out-of-range indices). Expected beats are queued on accept, observed beats
// are queued on transfer, and each test pops and compares them in order.
module tb_onehot_index_decoder;

    typedef struct packed {
        logic [7:0] onehot;
        logic       err;
        logic [7:0] thermo;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_err8;
    logic [2:0] in_idx8;
    logic [7:0] out_onehot8, err_cnt8, th8;

    logic       in_valid6, in_ready6, out_valid6, out_ready6, out_err6;
    logic [2:0] in_idx6;
    logic [5:0] out_onehot6, th6;
    logic [7:0] err_cnt6;

    beat_t exp8[$], obs8[$], exp6[$], obs6[$];
    int    obt8[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    beat_t ob, ex;

    always #5 clk = ~clk;

    onehot_index_decoder u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_idx     (in_idx8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .out_onehot (out_onehot8),
        .out_err    (out_err8),
        .err_cnt    (err_cnt8)
`ifdef ONEHOT_DEC_THERMO_EN
        ,
        .out_thermo (th8)
`endif
    );

    onehot_index_decoder #(
        .IDX_W (3),
        .OUT_W (6),
        .CNT_W (8)
    ) u_dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid6),
        .in_ready   (in_ready6),
        .in_idx     (in_idx6),
        .out_valid  (out_valid6),
        .out_ready  (out_ready6),
        .out_onehot (out_onehot6),
        .out_err    (out_err6),
        .err_cnt    (err_cnt6)
`ifdef ONEHOT_DEC_THERMO_EN
        ,
        .out_thermo (th6)
`endif
    );

`ifndef ONEHOT_DEC_THERMO_EN
    assign th8 = '0;
    assign th6 = '0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transferred beat, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            obs8.push_back({out_onehot8, out_err8, th8});
            obt8.push_back(cyc);
        end
        if (rst_n && out_valid6 && out_ready6) begin
            obs6.push_back({2'b00, out_onehot6, out_err6, 2'b00, th6});
        end
    end

    function automatic beat_t model(input int idx, input int outw);
        beat_t b;
        b = '0;
        if (idx < outw) begin
            b.onehot[idx] = 1'b1;
`ifdef ONEHOT_DEC_THERMO_EN
            for (int i = 0; i <= idx; i++) b.thermo[i] = 1'b1;
`endif
        end else begin
            b.err = 1'b1;
        end
        return b;
    endfunction

    // Drive one beat (called at posedge+1); returns at posedge+1 after the accepting edge.
    task automatic send(input bit use6, input logic [2:0] idx, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        if (use6) begin in_valid6 = 1'b1; in_idx6 = idx; end
        else begin in_valid8 = 1'b1; in_idx8 = idx; end
        while (!ok && waits <= 50) begin
            @(negedge clk);
            if (use6 ? in_ready6 : in_ready8) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready still %b after %0d cycles, required 1",
                     use6 ? in_ready6 : in_ready8, waits);
        end else if (use6) begin
            exp6.push_back(model(int'(idx), 6));
        end else begin
            exp8.push_back(model(int'(idx), 8));
        end
        @(posedge clk);
        #1;
        if (use6) in_valid6 = 1'b0;
        else in_valid8 = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid8, out_onehot8, out_err8, err_cnt8, in_ready8, th8} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b oh=%h err=%b cnt=%0d rdy=%b th=%h, required all 0",
                     out_valid8, out_onehot8, out_err8, err_cnt8, in_ready8, th8);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_early: got %b required 0", in_ready8);
        end
        @(posedge clk);
        #1;
        total++;
        if (in_ready8 !== 1'b1 || in_ready6 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise: got %b/%b required 1/1", in_ready8, in_ready6);
        end
    endtask

    task automatic test_latency();
        int w;
        out_ready8 = 1'b1;
        send(1'b0, 3'd5, w);
        total++;
        if (out_valid8 !== 1'b1 || out_onehot8 !== 8'b0010_0000 || out_err8 !== 1'b0) begin
            bad++;
            $display("FAIL latency_idx5: got v=%b oh=%b err=%b required 1 00100000 0",
                     out_valid8, out_onehot8, out_err8);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs8.size() != exp8.size()) begin
            bad++;
            $display("FAIL latency_count: got %0d beats, required %0d", obs8.size(), exp8.size());
        end
        while (obs8.size() > 0 && exp8.size() > 0) begin
            ob = obs8.pop_front();
            ex = exp8.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL latency_beat: got %h required %h", ob, ex);
            end
        end
        obs8.delete(); exp8.delete(); obt8.delete();
    endtask

    task automatic test_back_to_back();
        int w;
        out_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 3'(i), w);
            total++;
            if (w != 0) begin
                bad++;
                $display("FAIL b2b_ready idx=%0d: stalled %0d cycles, required 0", i, w);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs8.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats, required 8", obs8.size());
        end
        for (int i = 1; i < obt8.size(); i++) begin
            total++;
            if (obt8[i] != obt8[i-1] + 1) begin
                bad++;
                $display("FAIL b2b_gap beat %0d: got cycle %0d, required %0d",
                         i, obt8[i], obt8[i-1] + 1);
            end
        end
        while (obs8.size() > 0 && exp8.size() > 0) begin
            ob = obs8.pop_front();
            ex = exp8.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL b2b_beat: got %h required %h", ob, ex);
            end
        end
        total++;
        if (err_cnt8 !== 8'd0) begin
            bad++;
            $display("FAIL b2b_errcnt: got %0d required 0", err_cnt8);
        end
        obs8.delete(); exp8.delete(); obt8.delete();
    endtask

    task automatic test_backpressure();
        int w;
        out_ready8 = 1'b0;
        send(1'b0, 3'd2, w);
        send(1'b0, 3'd4, w);
        total++;
        if (in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_full_ready: got %b required 0", in_ready8);
        end
        in_valid8 = 1'b1;
        in_idx8   = 3'd6;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || out_onehot8 !== 8'h04) begin
            bad++;
            $display("FAIL bp_hold: got rdy=%b v=%b oh=%h required 0 1 04",
                     in_ready8, out_valid8, out_onehot8);
        end
        out_ready8 = 1'b1;
        send(1'b0, 3'd6, w);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs8.size() != 3) begin
            bad++;
            $display("FAIL bp_count: got %0d beats, required 3", obs8.size());
        end
        while (obs8.size() > 0 && exp8.size() > 0) begin
            ob = obs8.pop_front();
            ex = exp8.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL bp_order: got %h required %h", ob, ex);
            end
        end
        obs8.delete(); exp8.delete(); obt8.delete();
    endtask

    task automatic test_out_of_range();
        int w;
        out_ready6 = 1'b1;
        send(1'b1, 3'd7, w);
        total++;
        if (out_valid6 !== 1'b1 || out_onehot6 !== 6'd0 || out_err6 !== 1'b1 || err_cnt6 !== 8'd1)
        begin
            bad++;
            $display("FAIL oor_idx7: got v=%b oh=%b err=%b cnt=%0d required 1 000000 1 1",
                     out_valid6, out_onehot6, out_err6, err_cnt6);
        end
        send(1'b1, 3'd3, w);
        total++;
        if (out_onehot6 !== 6'b00_1000 || out_err6 !== 1'b0 || err_cnt6 !== 8'd1) begin
            bad++;
            $display("FAIL oor_inrange: got oh=%b err=%b cnt=%0d required 001000 0 1",
                     out_onehot6, out_err6, err_cnt6);
        end
        for (int i = 0; i < 300; i++) begin
            send(1'b1, ($urandom_range(1, 0) == 1) ? 3'd7 : 3'd6, w);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err_cnt6 !== 8'd255) begin
            bad++;
            $display("FAIL oor_saturate: got %0d required 255", err_cnt6);
        end
        total++;
        if (obs6.size() != exp6.size()) begin
            bad++;
            $display("FAIL oor_count: got %0d beats, required %0d", obs6.size(), exp6.size());
        end
        while (obs6.size() > 0 && exp6.size() > 0) begin
            ob = obs6.pop_front();
            ex = exp6.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL oor_beat: got %h required %h", ob, ex);
            end
        end
        obs6.delete(); exp6.delete();
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready8 = 1'b0;
        send(1'b0, 3'd1, w);
        send(1'b0, 3'd2, w);
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid8, out_onehot8, out_err8, in_ready8, th8, err_cnt6} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got v=%b oh=%h err=%b rdy=%b th=%h cnt6=%0d required all 0",
                     out_valid8, out_onehot8, out_err8, in_ready8, th8, err_cnt6);
        end
        exp8.delete(); obs8.delete(); obt8.delete();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release: got rdy=%b v=%b required 1 0", in_ready8, out_valid8);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs8.size() != 0) begin
            bad++;
            $display("FAIL midrst_stale: got %0d beats, required 0", obs8.size());
        end
        send(1'b0, 3'd1, w);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs8.size() != 1) begin
            bad++;
            $display("FAIL midrst_resume_count: got %0d beats, required 1", obs8.size());
        end
        while (obs8.size() > 0 && exp8.size() > 0) begin
            ob = obs8.pop_front();
            ex = exp8.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL midrst_resume_beat: got %h required %h", ob, ex);
            end
        end
        obs8.delete(); exp8.delete(); obt8.delete();
    endtask

`ifdef ONEHOT_DEC_THERMO_EN
    task automatic test_thermo();
        int w;
        out_ready8 = 1'b1;
        send(1'b0, 3'd3, w);
        total++;
        if (th8 !== 8'b0000_1111) begin
            bad++;
            $display("FAIL thermo_idx3: got %b required 00001111", th8);
        end
        send(1'b0, 3'd0, w);
        total++;
        if (th8 !== 8'b0000_0001) begin
            bad++;
            $display("FAIL thermo_idx0: got %b required 00000001", th8);
        end
        repeat (3) @(posedge clk);
        #1;
        while (obs8.size() > 0 && exp8.size() > 0) begin
            ob = obs8.pop_front();
            ex = exp8.pop_front();
            total++;
            if (ob !== ex) begin
                bad++;
                $display("FAIL thermo_beat: got %h required %h", ob, ex);
            end
        end
        obs8.delete(); exp8.delete(); obt8.delete();
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid8  = 1'b0;
        in_idx8    = '0;
        out_ready8 = 1'b0;
        in_valid6  = 1'b0;
        in_idx6    = '0;
        out_ready6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
`ifdef ONEHOT_DEC_THERMO_EN
        test_thermo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
